// File: rtl/branch_fwd_scoreboard_pkg.sv
// Shared types and constants for the ID-stage branch forwarding scoreboard.
package branch_fwd_scoreboard_pkg;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int unsigned REG_AW_MAX      = 8;
  localparam int unsigned FW_SEL_RF       = 0;
  localparam int unsigned ALU_RDY_IDX_DEF = 1;
  localparam int unsigned LD_RDY_IDX_DEF  = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

  function automatic int unsigned sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/brfwd_port_lookup.sv
// One branch read port: youngest matching scoreboard entry, readiness check,
// forwarding select and stall request.
module brfwd_port_lookup
  import branch_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned SELW        = sel_w(DEPTH),
  parameter int unsigned ALU_RDY_IDX = ALU_RDY_IDX_DEF,
  parameter int unsigned LD_RDY_IDX  = LD_RDY_IDX_DEF
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [REG_AW-1:0]     rd_addr_i,
  input  logic                  rd_en_i,
  output logic [SELW-1:0]       sel_c_o,
  output logic                  stall_c_o
);

  logic                  found;
  logic [REG_AW_MAX-1:0] addr_ext;

  assign addr_ext = REG_AW_MAX'(rd_addr_i);

  // Index 0 is the youngest writer; the first hit masks every older one.
  always_comb begin
    sel_c_o   = SELW'(FW_SEL_RF);
    stall_c_o = 1'b0;
    found     = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && rd_en_i && entries_i[i].valid &&
          (entries_i[i].dest != '0) && (entries_i[i].dest == addr_ext)) begin
        found = 1'b1;
        if (i >= (entries_i[i].is_load ? LD_RDY_IDX : ALU_RDY_IDX)) begin
          sel_c_o = SELW'(i + 1);
        end else begin
          stall_c_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// ID-stage branch operand forwarding scoreboard mirroring EX/MEM/WB writers.
// Define BRFWD_PERF_EN to add the stall-cycle and forward-event counters.
module branch_fwd_scoreboard
  import branch_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned ALU_RDY_IDX = ALU_RDY_IDX_DEF,
  parameter int unsigned LD_RDY_IDX  = LD_RDY_IDX_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic                               id_is_branch,
  input  logic [NUM_RD*REG_AW-1:0]           id_rd_addr,
  input  logic [NUM_RD-1:0]                  id_rd_used,
  input  logic                               id_regwrite,
  input  logic [REG_AW-1:0]                  id_dest,
  input  logic                               id_is_load,
  input  logic                               ext_stall,
  output logic [NUM_RD*sel_w(DEPTH)-1:0]     fw_sel,
  output logic                               br_stall
`ifdef BRFWD_PERF_EN
  ,
  output logic [31:0]                        perf_stall_cycles,
  output logic [31:0]                        perf_fwd_events
`endif
);

  localparam int unsigned SELW = sel_w(DEPTH);

  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t [DEPTH-1:0] sb_d;
  logic [NUM_RD-1:0]     port_stall;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    brfwd_port_lookup #(
      .REG_AW      (REG_AW),
      .DEPTH       (DEPTH),
      .SELW        (SELW),
      .ALU_RDY_IDX (ALU_RDY_IDX),
      .LD_RDY_IDX  (LD_RDY_IDX)
    ) u_lookup (
      .entries_i (sb_q),
      .rd_addr_i (id_rd_addr[p*REG_AW +: REG_AW]),
      .rd_en_i   (id_valid && id_is_branch && id_rd_used[p]),
      .sel_c_o   (fw_sel[p*SELW +: SELW]),
      .stall_c_o (port_stall[p])
    );
  end

  assign br_stall = |port_stall;

  // Shift toward WB; a stalled or empty ID slot enters EX as a bubble.
  always_comb begin
    sb_d = sb_q;
    if (!ext_stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0] = '0;
      if (id_valid && !br_stall) begin
        sb_d[0].valid   = id_regwrite;
        sb_d[0].dest    = REG_AW_MAX'(id_dest);
        sb_d[0].is_load = id_is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

`ifdef BRFWD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (br_stall && !ext_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((fw_sel != '0) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_fwd_events   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Self-checking bench for branch_fwd_scoreboard: directed hazard scenarios
// followed by randomized traffic against an issue-history reference model.
module tb_branch_fwd_scoreboard;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_RD  = 2;
  localparam int unsigned DEPTH   = 3;
  localparam int unsigned SELW    = 2;
  localparam int unsigned ALU_AGE = 1;
  localparam int unsigned LD_AGE  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     id_valid;
  logic                     id_is_branch;
  logic [NUM_RD*REG_AW-1:0] id_rd_addr;
  logic [NUM_RD-1:0]        id_rd_used;
  logic                     id_regwrite;
  logic [REG_AW-1:0]        id_dest;
  logic                     id_is_load;
  logic                     ext_stall;
  logic [NUM_RD*SELW-1:0]   fw_sel;
  logic                     br_stall;
`ifdef BRFWD_PERF_EN
  logic [31:0]              perf_stall_cycles;
  logic [31:0]              perf_fwd_events;
  bit   [31:0]              exp_pstall;
  bit   [31:0]              exp_pfwd;
`endif

  branch_fwd_scoreboard #(
    .REG_AW(REG_AW), .NUM_RD(NUM_RD), .DEPTH(DEPTH),
    .ALU_RDY_IDX(ALU_AGE), .LD_RDY_IDX(LD_AGE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_is_branch (id_is_branch),
    .id_rd_addr   (id_rd_addr),
    .id_rd_used   (id_rd_used),
    .id_regwrite  (id_regwrite),
    .id_dest      (id_dest),
    .id_is_load   (id_is_load),
    .ext_stall    (ext_stall),
    .fw_sel       (fw_sel),
    .br_stall     (br_stall)
`ifdef BRFWD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fwd_events   (perf_fwd_events)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of issued instructions, element 0 issued most recently.
  typedef struct { bit v; int unsigned dest; bit ld; } ment_t;
  ment_t       hist[$];
  int unsigned exp_sel[NUM_RD];
  bit          exp_stall;

  task automatic model_reset();
    ment_t e;
    e.v = 0; e.dest = 0; e.ld = 0;
    hist = {};
    repeat (DEPTH) hist.push_back(e);
`ifdef BRFWD_PERF_EN
    exp_pstall = 0;
    exp_pfwd   = 0;
`endif
  endtask

  // A producer of age a (0 = in EX) has its value available once a reaches its latency.
  task automatic model_eval();
    int unsigned addr;
    exp_stall = 0;
    for (int p = 0; p < NUM_RD; p++) begin
      exp_sel[p] = 0;
      addr = 32'(id_rd_addr[p*REG_AW +: REG_AW]);
      if (id_valid && id_is_branch && id_rd_used[p]) begin
        for (int a = 0; a < hist.size(); a++) begin
          if (hist[a].v && hist[a].dest != 0 && hist[a].dest == addr) begin
            if (a >= int'(hist[a].ld ? LD_AGE : ALU_AGE)) exp_sel[p] = a + 1;
            else exp_stall = 1;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    ment_t e;
    bit any_fwd;
    if (rst) begin
      model_reset();
    end else begin
      any_fwd = 0;
      for (int p = 0; p < NUM_RD; p++) if (exp_sel[p] != 0) any_fwd = 1;
`ifdef BRFWD_PERF_EN
      if (exp_stall && !ext_stall && exp_pstall != 32'hFFFF_FFFF) exp_pstall++;
      if (any_fwd && exp_pfwd != 32'hFFFF_FFFF) exp_pfwd++;
`endif
      if (!ext_stall) begin
        e.v    = id_valid && !exp_stall && id_regwrite;
        e.dest = 32'(id_dest);
        e.ld   = id_is_load;
        hist.push_front(e);
        void'(hist.pop_back());
      end
    end
  endtask

  // Compare against the model mid-cycle, then advance one clock.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("br_stall", 32'(br_stall), 32'(exp_stall));
    for (int p = 0; p < NUM_RD; p++)
      chk($sformatf("fw_sel%0d", p), 32'(fw_sel[p*SELW +: SELW]), 32'(exp_sel[p]));
`ifdef BRFWD_PERF_EN
    chk("perf_stall", perf_stall_cycles, exp_pstall);
    chk("perf_fwd", perf_fwd_events, exp_pfwd);
`endif
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit v, input bit br, input int a0, input int a1,
                        input bit [1:0] used, input bit rw, input int dst,
                        input bit ld, input bit es);
    id_valid     = v;
    id_is_branch = br;
    id_rd_addr   = {REG_AW'(a1), REG_AW'(a0)};
    id_rd_used   = used;
    id_regwrite  = rw;
    id_dest      = REG_AW'(dst);
    id_is_load   = ld;
    ext_stall    = es;
  endtask

  // Directed cycle with hand-derived expectations on top of the model check.
  task automatic step(input bit v, input bit br, input int a0, input int a1,
                      input bit [1:0] used, input bit rw, input int dst, input bit ld,
                      input bit es, input bit xs, input int x0, input int x1);
    rst = 0;
    set_in(v, br, a0, a1, used, rw, dst, ld, es);
    #1;
    chk("dir_stall", 32'(br_stall), 32'(xs));
    chk("dir_sel0", 32'(fw_sel[0 +: SELW]), 32'(x0));
    chk("dir_sel1", 32'(fw_sel[SELW +: SELW]), 32'(x1));
    cycle();
  endtask

  task automatic flush();
    repeat (DEPTH) step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1;
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // ALU writes $5, branch reads $5: one stall, then MEM forward
    step(1, 0, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 2, 0);
    flush();

    // lw $7 then beq on port 1: two stalls, then WB forward
    step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0, 0, 0, 0);
    step(1, 1, 0, 7, 2'b10, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 7, 2'b10, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, 3);
    flush();

    // lw $7, independent op, beq: one stall
    step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 3, 0);
    flush();

    // Two writers to $9 at MEM and WB: youngest wins, both ports
    step(1, 0, 0, 0, 2'b00, 1, 9, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 9, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 9, 2'b11, 0, 0, 0, 0, 0, 2, 2);
    flush();

    // Young unready load shadows an older ready ALU writer
    step(1, 0, 0, 0, 2'b00, 1, 9, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 9, 1, 0, 0, 0, 0);
    step(1, 1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 3, 0);
    flush();

    // $0 is never a hazard; unused operand and non-branch never stall
    step(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 4, 0, 0, 0, 0, 0);
    step(1, 1, 4, 4, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 4, 0, 0, 0, 0, 0);
    step(1, 0, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    flush();

    // ext_stall freezes a pending load hazard for three cycles
    step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 7, 0, 2'b01, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 3, 0);
    flush();

    // Reset in the middle of a stall
    step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0, 0, 0, 0);
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    rst = 1;
    cycle();
`ifdef BRFWD_PERF_EN
    chk("perf_stall_rst", perf_stall_cycles, 32'd0);
    chk("perf_fwd_rst", perf_fwd_events, 32'd0);
`endif
    step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    flush();

    // Randomized traffic over a small register range to provoke hazards
    repeat (1500) begin
      rst = ($urandom_range(99) == 0);
      set_in($urandom_range(9) != 0, $urandom_range(2) == 0,
             int'($urandom_range(7)), int'($urandom_range(7)),
             2'($urandom_range(3)), $urandom_range(3) != 0,
             int'($urandom_range(7)), $urandom_range(2) == 0,
             $urandom_range(9) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
